// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller.
// State encoding and counter sizing helper.
package serial_add_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit counter is one bit wider than needed to index WIDTH bits.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/full_adder1.sv
// One-bit full-adder cell built from two half-adders and an OR.
// Shared by the serial adder as its only arithmetic element.
module full_adder1 (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic hs1;
    logic hc1;
    logic hc2;

    assign hs1 = a ^ b;
    assign hc1 = a & b;
    assign s   = hs1 ^ ci;
    assign hc2 = hs1 & ci;
    assign co  = hc1 | hc2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell, LSB first,
// one bit per clock, with a start/busy/done handshake.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    full_adder1 u_fa (
        .a  (opa[0]),
        .b  (opb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE: state_nx = start ? ST_ADD : ST_IDLE;
            ST_ADD:  state_nx = (cnt == LAST) ? ST_DONE : ST_ADD;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // busy/done are registered from the state, so they trail it by a cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state == ST_ADD) || (state == ST_DONE);
            done  <= (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        res   <= '0;
                    end
                end
                ST_ADD: begin
                    res   <= {fa_s, res[WIDTH-1:1]};
                    carry <= fa_co;
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    cnt   <= cnt + 1'b1;
                end
                ST_DONE: begin
                    sum  <= res;
                    cout <= carry;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and back-to-back checks for serial_add_ctrl (WIDTH=8).
// Inputs driven and outputs sampled on the falling edge.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    int tests = 0;
    int fails = 0;
    int dcnt  = 0;

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) dcnt++;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; operands are scrambled after acceptance.
    task automatic pulse_start(input logic [7:0] ta, input logic [7:0] tb_,
                               input logic tci);
        a = ta;
        b = tb_;
        cin = tci;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic wait_done(output int n, output int bsy);
        n = 1;
        bsy = 0;
        while (!done && n < 40) begin
            if (busy) bsy++;
            @(negedge clk);
            n++;
        end
        if (busy) bsy++;
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_op(input string tag, input logic [7:0] ta,
                          input logic [7:0] tb_, input logic tci,
                          input logic [8:0] exp);
        int n;
        int bsy;
        pulse_start(ta, tb_, tci);
        wait_done(n, bsy);
        check({tag, "_lat"}, n, 10);
        check({tag, "_busy"}, bsy, 9);
        check({tag, "_res"}, {cout, sum}, exp);
        @(negedge clk);
        check({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        int n;
        int bsy;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rc;
        logic [8:0] rexp;

        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle", {busy, done, cout, sum}, 0);
        end

        run_op("basic", 8'h35, 8'h0A, 1'b0, 9'h03F);
        run_op("ripple1", 8'hFF, 8'h00, 1'b1, 9'h100);
        run_op("ripple2", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

        // A second start during ADD must be ignored.
        dcnt = 0;
        pulse_start(8'h01, 8'h01, 1'b0);
        repeat (2) @(negedge clk);
        pulse_start(8'h80, 8'h80, 1'b0);
        wait_done(n, bsy);
        check("ign_lat", n, 7);
        check("ign_res", {cout, sum}, 9'h002);
        repeat (15) @(negedge clk);
        check("ign_dcnt", dcnt, 1);

        // Reset during the fourth ADD cycle discards the operation.
        dcnt = 0;
        pulse_start(8'hAA, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid", {busy, done, cout, sum}, 0);
        repeat (15) @(negedge clk);
        check("rst_nodone", dcnt, 0);
        run_op("after_rst", 8'h10, 8'h20, 1'b0, 9'h030);

        // Back-to-back: restart on the done cycle itself.
        dcnt = 0;
        for (int i = 0; i < 200; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rexp = 9'(ra) + 9'(rb) + 9'(rc);
            pulse_start(ra, rb, rc);
            wait_done(n, bsy);
            check("b2b_lat", n, 10);
            check("b2b_res", {cout, sum}, rexp);
        end
        @(negedge clk);
        check("b2b_dcnt", dcnt, 200);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
